// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer that composes passes of 0..3 positions on an external combinational Shift_Unit.
// Optional SHIFT_SEQ_OPCNT_EN adds an 8-bit count of completed output handshakes.
module shift_sequencer #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    output logic [N-1:0]  su_dataa,
    output logic [1:0]    su_shamt,
    input  logic [N-1:0]  su_dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
`ifdef SHIFT_SEQ_OPCNT_EN
    ,
    output logic [7:0]    op_count
`endif
);

    // Remaining amount widened to at least 2 bits so the per-pass slice is always legal.
    localparam int RW = (AW < 2) ? 2 : AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [RW-1:0] rem_ext;
    logic [1:0]    pass_amt;

    assign rem_ext  = RW'(rem_q);
    assign pass_amt = (rem_ext >= RW'(3)) ? 2'd3 : rem_ext[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        su_shamt  = 2'd0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    rem_d   = in_amt;
                    // A zero amount bypasses the Shift_Unit entirely.
                    state_d = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                su_shamt = pass_amt;
                acc_d    = su_dataout;
                rem_d    = rem_q - AW'(pass_amt);
                if (rem_ext <= RW'(3)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign su_dataa = acc_q;
    assign out_data = acc_q;

`ifdef SHIFT_SEQ_OPCNT_EN
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == DONE && out_ready) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= 8'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a logical-left Shift_Unit model attached.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [7:0] su_dataa;
    logic [1:0] su_shamt;
    logic [7:0] su_dataout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
`ifdef SHIFT_SEQ_OPCNT_EN
    logic [7:0] op_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] opcnt_exp = 8'd0;

    shift_sequencer #(.N(8), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .su_dataa   (su_dataa),
        .su_shamt   (su_shamt),
        .su_dataout (su_dataout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
`ifdef SHIFT_SEQ_OPCNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    // Attached Shift_Unit: logical left, zero fill.
    assign su_dataout = su_dataa << su_shamt;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] exp;
        int         cyc;
        logic [5:0] seq;   // {pass2, pass1, pass0}
    } vec_t;

    // Accept one request with out_ready=1 and verify pass sequence, result and turnaround.
    task automatic run_vec(input vec_t v);
        int cyc;
        logic [5:0] seq;
        chk({v.name, "_in_ready_pre"}, in_ready, 1);
        in_data   = v.data;
        in_amt    = v.amt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        seq = '0;
        while (!out_valid && cyc < 8) begin
            if (cyc < 3) seq[cyc*2 +: 2] = su_shamt;
            @(negedge clk);
            cyc++;
        end
        chk({v.name, "_cycles"}, cyc, v.cyc);
        chk({v.name, "_shamt_seq"}, seq, v.seq);
        chk({v.name, "_out_valid"}, out_valid, 1);
        chk({v.name, "_out_data"}, out_data, v.exp);
        chk({v.name, "_done_shamt"}, su_shamt, 0);
        @(negedge clk);
        opcnt_exp++;
        chk({v.name, "_in_ready_post"}, in_ready, 1);
        chk({v.name, "_out_valid_post"}, out_valid, 0);
`ifdef SHIFT_SEQ_OPCNT_EN
        chk({v.name, "_op_count"}, op_count, opcnt_exp);
`endif
    endtask

    vec_t vecs[9];

    initial begin
        bit seen_valid;
        vec_t v;

        vecs[0] = '{"ff_by0", 8'hFF, 3'd0, 8'hFF, 0, 6'b00_00_00};
        vecs[1] = '{"ff_by7", 8'hFF, 3'd7, 8'h80, 3, 6'b01_11_11};
        vecs[2] = '{"01_by5", 8'h01, 3'd5, 8'h20, 2, 6'b00_10_11};
        vecs[3] = '{"03_by3", 8'h03, 3'd3, 8'h18, 1, 6'b00_00_11};
        vecs[4] = '{"a5_by1", 8'hA5, 3'd1, 8'h4A, 1, 6'b00_00_01};
        vecs[5] = '{"81_by2", 8'h81, 3'd2, 8'h04, 1, 6'b00_00_10};
        vecs[6] = '{"0f_by4", 8'h0F, 3'd4, 8'hF0, 2, 6'b00_01_11};
        vecs[7] = '{"c3_by6", 8'hC3, 3'd6, 8'hC0, 2, 6'b00_11_11};
        vecs[8] = '{"55_by7", 8'h55, 3'd7, 8'h80, 3, 6'b01_11_11};

        // Reset held two cycles with a request pending.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_amt = 3'd5; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_su_shamt", su_shamt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_su_dataa", su_dataa, 0);
`ifdef SHIFT_SEQ_OPCNT_EN
        chk("rst_op_count", op_count, 0);
`endif
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", in_ready, 1);
        chk("post_rst_no_accept", out_data, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Result held while consumer stalls; a request during the hold is ignored.
        in_data = 8'h01; in_amt = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_shamt0", su_shamt, 3);
        @(negedge clk);
        chk("hold_shamt1", su_shamt, 2);
        @(negedge clk);
        in_data = 8'hFF; in_amt = 3'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, 8'h20);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("hold_still_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        opcnt_exp++;
        out_ready = 1'b0;
        chk("hold_released_in_ready", in_ready, 1);
        chk("hold_released_out_valid", out_valid, 0);
        chk("hold_no_second_accept", out_data, 8'h20);
`ifdef SHIFT_SEQ_OPCNT_EN
        chk("hold_op_count", op_count, opcnt_exp);
`endif

        // Reset on the second SHIFT cycle aborts the operation.
        in_data = 8'h77; in_amt = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
        seen_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_shift1_busy", busy, 1);
        seen_valid |= out_valid;
        @(negedge clk);
        chk("abort_shift2_shamt", su_shamt, 3);
        seen_valid |= out_valid;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcnt_exp = 8'd0;
        seen_valid |= out_valid;
        chk("abort_idle", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", out_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen_valid |= out_valid;
        end
        chk("abort_no_out_valid", seen_valid, 0);
`ifdef SHIFT_SEQ_OPCNT_EN
        chk("abort_op_count", op_count, 0);
`endif
        v = '{"after_abort", 8'h03, 3'd3, 8'h18, 1, 6'b00_00_11};
        run_vec(v);

`ifdef SHIFT_SEQ_OPCNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcnt_exp = 8'd0;
        chk("opcnt_cleared", op_count, 0);
        v = '{"opcnt", 8'h5A, 3'd0, 8'h5A, 0, 6'b00_00_00};
        for (int i = 0; i < 257; i++) run_vec(v);
        chk("opcnt_wrap", op_count, 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
